// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer: state codes, op codes, default latencies.
package muldiv_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int unsigned DEF_MUL_LATENCY = 33;
  localparam int unsigned DEF_DIV_LATENCY = 34;
  localparam int unsigned DEF_CNT_W       = 6;

endpackage

// File: rtl/muldiv_hilo.sv
// Architectural HI/LO register pair: unit writeback has priority over MTHI/MTLO writes.
module muldiv_hilo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wb_en,
  input  logic [31:0] i_res_hi,
  input  logic [31:0] i_res_lo,
  input  logic        i_mthi_we,
  input  logic        i_mtlo_we,
  input  logic [31:0] i_wr_data,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // HI/LO update: operation result, else individual move-to writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_wb_en) begin
      r_hi <= i_res_hi;
      r_lo <= i_res_lo;
    end else begin
      if (i_mthi_we) r_hi <= i_wr_data;
      if (i_mtlo_we) r_lo <= i_wr_data;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the shared multi-cycle multiply/divide units: operand latch, start pulse,
// latency count, HI/LO writeback, pipeline stall and divide-by-zero exception.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int unsigned DIV_LATENCY = DEF_DIV_LATENCY,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] wr_data,
  input  logic [31:0] mul_high,
  input  logic [31:0] mul_low,
  input  logic [31:0] div_high,
  input  logic [31:0] div_low,
  input  logic        div_div0,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mul_start,
  output logic        div_start,
  output logic        unit_rst,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0_exc
);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             r_div0_exc;

  logic             w_idle;
  logic             w_req_div0;
  logic             w_accept;
  logic [CNT_W-1:0] w_lat_end;
  logic             w_mthi_we;
  logic             w_mtlo_we;
  logic [31:0]      w_res_hi;
  logic [31:0]      w_res_lo;
  logic             w_unused_div0;

  // Zero divisor is detected on the incoming op_b, so the unit's own flag is not needed here.
  assign w_unused_div0 = div_div0;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_req_div0 = (op_is_div == OP_DIV) && (op_b == '0);
  assign w_accept   = w_idle && op_valid && !w_req_div0;
  assign w_lat_end  = r_is_div ? CNT_W'(DIV_LATENCY - 1) : CNT_W'(MUL_LATENCY - 1);

  // Main FSM, latency counter and operand/op-kind latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_is_div <= OP_MULT;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            r_a      <= op_a;
            r_b      <= op_b;
            r_is_div <= op_is_div;
            if (!w_req_div0) r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= CNT_W'(1);
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == w_lat_end) r_state <= ST_WB;
        end
        ST_WB: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Divide-by-zero exception pulse, one cycle after the rejected request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_div0_exc <= 1'b0;
    else        r_div0_exc <= w_idle && op_valid && w_req_div0;
  end

  // Result source follows the latched op kind
  always_comb begin
    w_res_hi = mul_high;
    w_res_lo = mul_low;
    if (r_is_div) begin
      w_res_hi = div_high;
      w_res_lo = div_low;
    end
  end

  assign w_mthi_we = w_idle && !op_valid && mthi_we;
  assign w_mtlo_we = w_idle && !op_valid && mtlo_we;

  muldiv_hilo u_hilo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wb_en   (r_state == ST_WB),
    .i_res_hi  (w_res_hi),
    .i_res_lo  (w_res_lo),
    .i_mthi_we (w_mthi_we),
    .i_mtlo_we (w_mtlo_we),
    .i_wr_data (wr_data),
    .o_hi      (hi),
    .o_lo      (lo)
  );

  assign unit_a    = r_a;
  assign unit_b    = r_b;
  assign mul_start = (r_state == ST_ISSUE) && !r_is_div;
  assign div_start = (r_state == ST_ISSUE) && r_is_div;
  assign unit_rst  = ~rst_n;
  assign busy      = (r_state == ST_ISSUE) || (r_state == ST_RUN) || w_accept;
  assign done      = (r_state == ST_WB);
  assign div0_exc  = r_div0_exc;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: behavioural mul/div units plus a HI/LO and timing model.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 33;
  localparam int DIV_LAT = 34;

  logic        clk;
  logic        rst_n;
  logic        op_valid, op_is_div;
  logic [31:0] op_a, op_b;
  logic        mthi_we, mtlo_we;
  logic [31:0] wr_data;
  logic [31:0] mul_high, mul_low, div_high, div_low;
  logic        div_div0;
  logic [31:0] unit_a, unit_b;
  logic        mul_start, div_start, unit_rst;
  logic [31:0] hi, lo;
  logic        busy, done, div0_exc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi, m_lo;

  muldiv_ctrl #(.MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_is_div(op_is_div),
    .op_a(op_a), .op_b(op_b), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wr_data(wr_data),
    .mul_high(mul_high), .mul_low(mul_low), .div_high(div_high), .div_low(div_low),
    .div_div0(div_div0), .unit_a(unit_a), .unit_b(unit_b), .mul_start(mul_start),
    .div_start(div_start), .unit_rst(unit_rst), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .div0_exc(div0_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] ref_result(input logic is_div, input logic [31:0] a,
                                              input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic signed [63:0] p;
    sa = a;
    sb = b;
    if (is_div) return {32'(sa % sb), 32'(sa / sb)};
    p = sa * sb;
    return p;
  endfunction

  // Behavioural units: result appears LAT edges after the start sample edge, garbage before.
  int unsigned nedge = 0;
  int unsigned mul_due, div_due;
  bit          mul_pend = 0, div_pend = 0;
  logic [63:0] mul_res, div_res;
  always @(negedge clk) begin
    nedge++;
    if (!rst_n) begin
      mul_pend = 0;
      div_pend = 0;
    end
    if (mul_start) begin
      mul_pend = 1;
      mul_due  = nedge + MUL_LAT;
      mul_res  = ref_result(1'b0, unit_a, unit_b);
    end
    if (div_start) begin
      div_pend = 1;
      div_due  = nedge + DIV_LAT;
      div_res  = ref_result(1'b1, unit_a, unit_b);
    end
    if (mul_pend && nedge >= mul_due) {mul_high, mul_low} = mul_res;
    else {mul_high, mul_low} = {32'hBAD0_0001, 32'hBAD0_0002};
    if (div_pend && nedge >= div_due) {div_high, div_low} = div_res;
    else {div_high, div_low} = {32'hBAD0_0003, 32'hBAD0_0004};
    div_div0 = (unit_b == 32'd0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, input bit mt_at_accept);
    logic [63:0] r;
    int lat, sm, sd, done_at, unstable, busy_drop, hold_err;
    bit seen;
    r   = ref_result(is_div, a, b);
    lat = is_div ? DIV_LAT : MUL_LAT;
    @(negedge clk);
    op_valid = 1; op_is_div = is_div; op_a = a; op_b = b;
    if (mt_at_accept) begin
      mthi_we = 1; mtlo_we = 1; wr_data = 32'h5A5A_A5A5;
    end
    #1 chk("busy_accept", busy, 1);
    @(negedge clk);
    op_valid = 0; mthi_we = 0; mtlo_we = 0; op_a = ~a; op_b = ~b;
    chk("unit_a_latch", unit_a, a);
    chk("unit_b_latch", unit_b, b);
    chk("hilo_hold_issue", {hi, lo}, {m_hi, m_lo});
    sm = 0; sd = 0; done_at = 0; unstable = 0; busy_drop = 0; hold_err = 0; seen = 0;
    for (int cyc = 1; cyc <= lat + 10 && !seen; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (mul_start) sm++;
      if (div_start) sd++;
      if (unit_a !== a || unit_b !== b) unstable++;
      if (done) begin
        seen = 1;
        done_at = cyc;
        chk("busy_wb", busy, 0);
        chk("div0_at_done", div0_exc, 0);
      end else begin
        if (!busy) busy_drop++;
        if (hi !== m_hi || lo !== m_lo) hold_err++;
      end
      if (inject && cyc == 5) begin
        op_valid = 1; op_is_div = ~is_div; mtlo_we = 1; wr_data = 32'hDEADBEEF;
      end
      if (inject && cyc == 6) begin
        op_valid = 0; mtlo_we = 0;
      end
    end
    chk("done_cycle", done_at, lat + 1);
    chk("mul_starts", sm, is_div ? 0 : 1);
    chk("div_starts", sd, is_div ? 1 : 0);
    chk("operand_stable", unstable, 0);
    chk("busy_drop", busy_drop, 0);
    chk("hilo_hold_run", hold_err, 0);
    @(negedge clk);
    {m_hi, m_lo} = r;
    chk("hi_result", hi, m_hi);
    chk("lo_result", lo, m_lo);
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic div0_req(input logic [31:0] a);
    @(negedge clk);
    op_valid = 1; op_is_div = 1; op_a = a; op_b = 0;
    #1 chk("busy_div0_req", busy, 0);
    @(negedge clk);
    op_valid = 0;
    chk("div0_pulse", div0_exc, 1);
    chk("div0_no_start", div_start, 0);
    chk("div0_busy", busy, 0);
    chk("div0_hilo", {hi, lo}, {m_hi, m_lo});
    @(negedge clk);
    chk("div0_pulse_end", div0_exc, 0);
    chk("div0_no_start2", {div_start, mul_start, busy}, 0);
  endtask

  task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    mthi_we = h; mtlo_we = l; wr_data = d;
    #1 chk("busy_mt", busy, 0);
    @(negedge clk);
    mthi_we = 0; mtlo_we = 0;
    if (h) m_hi = d;
    if (l) m_lo = d;
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
  endtask

  initial begin
    rst_n = 0; op_valid = 0; op_is_div = 0; op_a = '0; op_b = '0;
    mthi_we = 0; mtlo_we = 0; wr_data = '0;
    mul_high = '0; mul_low = '0; div_high = '0; div_low = '0; div_div0 = 0;
    repeat (3) @(negedge clk);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_units", {unit_a, unit_b}, 0);
    chk("rst_pulses", {mul_start, div_start, done, div0_exc, busy}, 0);
    chk("rst_unit_rst", unit_rst, 1);
    rst_n = 1;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    chk("unit_rst_rel", unit_rst, 0);

    run_op(1, 32'd7, 32'd2, 0, 0);
    run_op(1, 32'hFFFF_FFF9, 32'd2, 0, 0);
    div0_req(32'd5);
    run_op(0, 32'h0001_0000, 32'h0001_0000, 0, 0);
    run_op(1, 32'd100, 32'd7, 1, 0);
    mt_write(0, 1, 32'hDEADBEEF);
    mt_write(1, 0, 32'h1234_5678);

    // Abort a DIV mid-run with reset
    @(negedge clk);
    op_valid = 1; op_is_div = 1; op_a = 32'd1234; op_b = 32'd5;
    @(negedge clk);
    op_valid = 0;
    repeat (10) @(negedge clk);
    rst_n = 0;
    #1;
    m_hi = '0; m_lo = '0;
    chk("rstmid_hilo", {hi, lo}, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_unit_rst", unit_rst, 1);
    chk("rstmid_unit_a", unit_a, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rstmid_idle", {busy, done, div_start}, 0);
    run_op(1, 32'd1000, 32'd33, 0, 0);

    mt_write(1, 1, 32'hCAFE_F00D);
    run_op(0, 32'hFFFF_FFFF, 32'd3, 0, 1);
    run_op(0, 32'h8000_0000, 32'd0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      logic        d;
      logic [31:0] a, b;
      d = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (d && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      case ($urandom_range(0, 5))
        0:       div0_req(a);
        1:       mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        default: run_op(d, a, b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
